seq_det_ctrl: RTL

SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

---
 rtl/seq_det_pkg.sv | 14 +
 rtl/seq_det_if.sv | 33 +++
 rtl/seq_det_core.sv | 47 ++++
 rtl/seq_det_ctrl.sv | 86 ++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial pattern detector: state encoding and
// default widths used by seq_det_core, seq_det_if and seq_det_ctrl.
package seq_det_pkg;

   localparam int DEF_PAT_W = 4;
   localparam int DEF_CNT_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ARMED = 2'b01,
      ST_DONE  = 2'b10
   } state_t;

endpackage

// File: rtl/seq_det_if.sv
// Control/data bundle of the pattern detector. The slave side is the
// detector itself, the master side is whoever configures and feeds it.
interface seq_det_if
   import seq_det_pkg::*;
#(
   parameter int PAT_W = DEF_PAT_W,
   parameter int CNT_W = DEF_CNT_W
);
   logic             cfg_we;
   logic [PAT_W-1:0] cfg_pattern;
   logic [CNT_W-1:0] cfg_target;
   logic             start;
   logic             abort;
   logic             in_valid;
   logic             in_bit;
   logic             done_ack;
   logic             det;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] match_count;

   modport master (
      output cfg_we, cfg_pattern, cfg_target, start, abort,
             in_valid, in_bit, done_ack,
      input  det, busy, done, match_count
   );

   modport slave (
      input  cfg_we, cfg_pattern, cfg_target, start, abort,
             in_valid, in_bit, done_ack,
      output det, busy, done, match_count
   );
endinterface

// File: rtl/seq_det_core.sv
// History shift register, fill counter and pattern comparator.
// match_o is combinational and refers to the bit being shifted in this cycle.
// Build option SEQ_DET_NONOVERLAP_EN: a match empties the fill counter so
// the next match needs PAT_W fresh bits (default: overlapping detection).
module seq_det_core
   import seq_det_pkg::*;
#(
   parameter int PAT_W = DEF_PAT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr_i,
   input  logic             shift_i,
   input  logic             bit_i,
   input  logic [PAT_W-1:0] pattern_i,
   output logic             match_o
);
   localparam int FILL_W = $clog2(PAT_W + 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

   logic [PAT_W-1:0]  hist_q, hist_d;
   logic [FILL_W-1:0] fill_q, fill_d, fill_inc;

   // Post-shift history, saturating fill count and match decision.
   always_comb begin
      hist_d   = {hist_q[PAT_W-2:0], bit_i};
      fill_inc = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
      match_o  = shift_i && (fill_inc == FILL_FULL) && (hist_d == pattern_i);
      fill_d   = fill_inc;
`ifdef SEQ_DET_NONOVERLAP_EN
      if (match_o) begin
         fill_d = '0;
      end
`endif
   end

   // History and fill only move on qualified bits; start wipes them.
   always_ff @(posedge clk) begin
      if (reset || clr_i) begin
         hist_q <= '0;
         fill_q <= '0;
      end else if (shift_i) begin
         hist_q <= hist_d;
         fill_q <= fill_d;
      end
   end
endmodule

// File: rtl/seq_det_ctrl.sv
// Serial pattern detector top: IDLE/ARMED/DONE control FSM, configuration
// registers and saturating match counter around seq_det_core.
// Build option SEQ_DET_NONOVERLAP_EN selects non-overlapping detection.
module seq_det_ctrl
   import seq_det_pkg::*;
#(
   parameter int PAT_W = DEF_PAT_W,
   parameter int CNT_W = DEF_CNT_W
) (
   input logic      clk,
   input logic      reset,
   seq_det_if.slave bus_io
);
   state_t           state_q;
   logic [PAT_W-1:0] pattern_q;
   logic [CNT_W-1:0] target_q;
   logic [CNT_W-1:0] count_q, count_inc_d;
   logic             det_q;
   logic             clr_d, shift_d, match_d;

   // Qualify core strobes with state; abort suppresses everything.
   always_comb begin
      clr_d       = (state_q == ST_IDLE) && bus_io.start && !bus_io.abort;
      shift_d     = (state_q == ST_ARMED) && bus_io.in_valid && !bus_io.abort;
      count_inc_d = (count_q == '1) ? count_q : count_q + 1'b1;
   end

   seq_det_core #(.PAT_W(PAT_W)) u_core (
      .clk       (clk),
      .reset     (reset),
      .clr_i     (clr_d),
      .shift_i   (shift_d),
      .bit_i     (bus_io.in_bit),
      .pattern_i (pattern_q),
      .match_o   (match_d)
   );

   // Control FSM with registered det pulse, configuration and counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         pattern_q <= '0;
         target_q  <= '0;
         count_q   <= '0;
         det_q     <= 1'b0;
      end else begin
         det_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (!bus_io.abort) begin
                  if (bus_io.cfg_we) begin
                     pattern_q <= bus_io.cfg_pattern;
                     target_q  <= bus_io.cfg_target;
                  end
                  if (bus_io.start) begin
                     count_q <= '0;
                     state_q <= ST_ARMED;
                  end
               end
            end
            ST_ARMED: begin
               if (bus_io.abort) begin
                  state_q <= ST_IDLE;
               end else if (match_d) begin
                  det_q   <= 1'b1;
                  count_q <= count_inc_d;
                  if ((target_q != '0) && (count_inc_d == target_q)) begin
                     state_q <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               if (bus_io.abort || bus_io.done_ack) begin
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus_io.det         = det_q;
   assign bus_io.busy        = (state_q == ST_ARMED);
   assign bus_io.done        = (state_q == ST_DONE);
   assign bus_io.match_count = count_q;
endmodule
